// File: rtl/uart_text_console.sv
// UART byte stream to LCD text VRAM writer: cursor tracking, control codes,
// line wrap with row clearing, and an input FIFO that keeps filling during clears.
module uart_text_console #(
    parameter int         COLS       = 50,
    parameter int         ROWS       = 15,
    parameter int         ADDR_W     = 12,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] BLANK      = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              clear_req,
    output logic              vram_ce,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_data,
    output logic [5:0]        cursor_col,
    output logic [3:0]        cursor_row,
    output logic              busy,
    output logic              overflow
);

    localparam int                PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [5:0]        LAST_COL   = 6'(COLS - 1);
    localparam logic [3:0]        LAST_ROW   = 4'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LINE_END   = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] SCREEN_END = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(COLS);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_PUT, S_CLEAR_LINE, S_CLEAR_ALL
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        char_q, char_d;
    logic              bs_q, bs_d;
    logic [5:0]        col_q, col_d;
    logic [3:0]        row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              vram_ce_q, vram_ce_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]        vram_data_q, vram_data_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        mem_q [FIFO_DEPTH];

    logic              fifo_empty, fifo_full, push, pop, is_print, last_row;
    logic [3:0]        next_row;
    logic [ADDR_W-1:0] next_base;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    // A pending or fresh clear takes priority over draining the FIFO.
    assign pop        = (state_q == S_IDLE) && !pend_q && !clear_req && !fifo_empty;
    assign push       = rx_valid && (!fifo_full || pop);
    assign is_print   = (char_q >= 8'h20) && (char_q <= 8'h7E);
    assign last_row   = (row_q == LAST_ROW);
    assign next_row   = last_row ? 4'd0 : row_q + 4'd1;
    assign next_base  = last_row ? '0 : row_base_q + ROW_STEP;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= rx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_CLEAR_ALL;
            char_q      <= '0;
            bs_q        <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            row_base_q  <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            vram_ce_q   <= 1'b0;
            vram_addr_q <= '0;
            vram_data_q <= '0;
            busy_q      <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            char_q      <= char_d;
            bs_q        <= bs_d;
            col_q       <= col_d;
            row_q       <= row_d;
            row_base_q  <= row_base_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            vram_ce_q   <= vram_ce_d;
            vram_addr_q <= vram_addr_d;
            vram_data_q <= vram_data_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q || clear_req) state_d = S_CLEAR_ALL;
                else if (!fifo_empty)    state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_print)                           state_d = S_PUT;
                else if (char_q == 8'h0A)               state_d = S_CLEAR_LINE;
                else if (char_q == 8'h08 && col_q != 0) state_d = S_PUT;
                else if (char_q == 8'h0C)               state_d = S_CLEAR_ALL;
                else                                    state_d = S_IDLE;
            end
            S_PUT:        state_d = (!bs_q && col_q == LAST_COL) ? S_CLEAR_LINE : S_IDLE;
            S_CLEAR_LINE: if (cnt_q == LINE_END)   state_d = S_IDLE;
            S_CLEAR_ALL:  if (cnt_q == SCREEN_END) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        char_d      = char_q;
        bs_d        = bs_q;
        col_d       = col_q;
        row_d       = row_q;
        row_base_d  = row_base_q;
        pend_d      = pend_q;
        vram_ce_d   = 1'b0;
        vram_addr_d = vram_addr_q;
        vram_data_d = vram_data_q;
        wr_ptr_d    = wr_ptr_q + (PTR_W + 1)'(push);
        rd_ptr_d    = rd_ptr_q + (PTR_W + 1)'(pop);
        overflow_d  = rx_valid && !push;
        busy_d      = (state_d != S_IDLE);
        cnt_d       = ((state_q == S_CLEAR_LINE || state_q == S_CLEAR_ALL) && state_d == state_q)
                      ? cnt_q + 1'b1 : '0;
        if (clear_req && state_q != S_IDLE && state_q != S_CLEAR_ALL) pend_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    char_d = mem_q[rd_ptr_q[PTR_W-1:0]];
                    bs_d   = 1'b0;
                end
            end
            S_DECODE: begin
                if (!is_print) begin
                    if (char_q == 8'h0D) col_d = '0;
                    if (char_q == 8'h0A) begin
                        row_d      = next_row;
                        row_base_d = next_base;
                    end
                    // Backspace reuses PUT to blank the cell without moving the cursor again.
                    if (char_q == 8'h08 && col_q != 0) begin
                        col_d  = col_q - 6'd1;
                        char_d = BLANK;
                        bs_d   = 1'b1;
                    end
                end
            end
            S_PUT: begin
                vram_ce_d   = 1'b1;
                vram_addr_d = row_base_q + ADDR_W'(col_q);
                vram_data_d = char_q;
                if (!bs_q) begin
                    if (col_q == LAST_COL) begin
                        col_d      = '0;
                        row_d      = next_row;
                        row_base_d = next_base;
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            S_CLEAR_LINE: begin
                vram_ce_d   = 1'b1;
                vram_addr_d = row_base_q + cnt_q;
                vram_data_d = BLANK;
            end
            S_CLEAR_ALL: begin
                vram_ce_d   = 1'b1;
                vram_addr_d = cnt_q;
                vram_data_d = BLANK;
                if (cnt_q == SCREEN_END) begin
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = '0;
                    pend_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign vram_ce    = vram_ce_q;
    assign vram_addr  = vram_addr_q;
    assign vram_data  = vram_data_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_text_console.sv
// Bench for uart_text_console: a screen/cursor model turns the sent byte stream
// into the expected list of VRAM writes, compared against captured writes.
module tb_uart_text_console;

    localparam int COLS = 50;
    localparam int ROWS = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        clear_req;
    logic        vram_ce;
    logic [11:0] vram_addr;
    logic [7:0]  vram_data;
    logic [5:0]  cursor_col;
    logic [3:0]  cursor_row;
    logic        busy;
    logic        overflow;

    uart_text_console dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .clear_req  (clear_req),
        .vram_ce    (vram_ce),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          ovf_cnt = 0;
    int          m_col = 0;
    int          m_row = 0;
    logic [11:0] got_addr[$];
    logic [7:0]  got_data[$];
    int          got_cyc[$];
    logic [11:0] exp_addr[$];
    logic [7:0]  exp_data[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (vram_ce === 1'b1) begin
            got_addr.push_back(vram_addr);
            got_data.push_back(vram_data);
            got_cyc.push_back(cyc);
        end
        if (overflow === 1'b1) ovf_cnt = ovf_cnt + 1;
    end

    // Reference model: screen semantics expressed directly as row/column arithmetic.
    task automatic exp_put(input int a, input logic [7:0] d);
        exp_addr.push_back(12'(a));
        exp_data.push_back(d);
    endtask

    task automatic model_line();
        for (int c = 0; c < COLS; c++) exp_put(m_row * COLS + c, 8'h20);
    endtask

    task automatic model_clear_all();
        for (int a = 0; a < COLS * ROWS; a++) exp_put(a, 8'h20);
        m_col = 0;
        m_row = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_put(m_row * COLS + m_col, b);
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
                model_line();
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_row = (m_row + 1) % ROWS;
            model_line();
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_put(m_row * COLS + m_col, 8'h20);
            end
        end else if (b == 8'h0C) begin
            model_clear_all();
        end
    endtask

    task automatic flush();
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        exp_addr.delete(); exp_data.delete();
        ovf_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int quiet = 0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) quiet++; else quiet = 0;
            if (quiet >= 4) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        bit ok;
        repeat (3) @(negedge clk);
        checks++;
        if (vram_ce !== 1'b0 || vram_addr !== 12'd0 || vram_data !== 8'd0 || busy !== 1'b1 ||
            overflow !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 4'd0) begin
            errors++;
            $display("FAIL reset_values ce=%b addr=%0d data=%h busy=%b ovf=%b col=%0d row=%0d, required 0 0 00 1 0 0 0",
                     vram_ce, vram_addr, vram_data, busy, overflow, cursor_col, cursor_row);
        end
        flush();
        m_col = 0; m_row = 0;
        model_clear_all();
        @(posedge clk); #1 reset = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL init_timeout busy never dropped"); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL init_count got %0d writes, required %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] !== got_cyc[0] + i) begin
                errors++;
                $display("FAIL init_write[%0d] got %0d/%h cyc+%0d, required %0d/%h cyc+%0d", i,
                         got_addr[i], got_data[i], got_cyc[i] - got_cyc[0], exp_addr[i], exp_data[i], i);
            end
        end
        checks++;
        if (cursor_col !== 6'd0 || cursor_row !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL init_cursor col=%0d row=%0d busy=%b, required 0 0 0", cursor_col, cursor_row, busy);
        end
    endtask

    task automatic test_latency();
        bit ok;
        int c0;
        flush();
        model_byte(8'h41);
        @(posedge clk); #1;
        c0 = cyc;
        rx_data = 8'h41; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
        repeat (8) @(posedge clk);
        model_byte(8'h42);
        send_byte(8'h42);
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL latency_timeout"); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL latency_count got %0d, required %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL latency_write[%0d] got %0d/%h, required %0d/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (got_cyc.size() == 0 || got_cyc[0] !== c0 + 4) begin
            errors++; $display("FAIL latency_first_ce got cycle %0d, required %0d", got_cyc.size() ? got_cyc[0] - c0 : -1, 4);
        end
        checks++;
        if (cursor_col !== 6'd2) begin errors++; $display("FAIL latency_col got %0d, required 2", cursor_col); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] b;
        flush();
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(8'h21, 8'h7E));
            model_byte(b);
            rx_data = b; rx_valid = 1'b1;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_timeout"); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL b2b_count got %0d, required %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || (i > 0 && got_cyc[i] - got_cyc[i-1] != 3)) begin
                errors++; $display("FAIL b2b_write[%0d] got %0d/%h gap %0d, required %0d/%h gap 3", i, got_addr[i], got_data[i],
                                   i > 0 ? got_cyc[i] - got_cyc[i-1] : 3, exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (cursor_col !== 6'(m_col)) begin errors++; $display("FAIL b2b_col got %0d, required %0d", cursor_col, m_col); end
    endtask

    task automatic test_wrap();
        bit ok;
        flush();
        model_byte(8'h0D);
        send_byte(8'h0D);
        for (int i = 0; i < COLS; i++) begin
            model_byte(8'h78);
            send_byte(8'h78);
            repeat (2) @(posedge clk);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_timeout"); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL wrap_count got %0d, required %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL wrap_write[%0d] got %0d/%h, required %0d/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (cursor_col !== 6'd0 || cursor_row !== 4'd1) begin
            errors++; $display("FAIL wrap_cursor got %0d,%0d, required 0,1", cursor_col, cursor_row);
        end
    endtask

    task automatic test_backspace();
        bit ok;
        flush();
        model_byte(8'h0D); send_byte(8'h0D);
        for (int i = 0; i < 3; i++) begin
            model_byte(8'h61 + 8'(i)); send_byte(8'h61 + 8'(i));
        end
        wait_idle(ok);
        flush();
        model_byte(8'h08); send_byte(8'h08);
        wait_idle(ok);
        checks++;
        if (got_addr.size() != 1 || got_addr[0] !== exp_addr[0] || got_data[0] !== 8'h20) begin
            errors++; $display("FAIL bs_write got %0d writes first %0d/%h, required 1 write %0d/20", got_addr.size(),
                               got_addr.size() ? got_addr[0] : 0, got_data.size() ? got_data[0] : 0, exp_addr[0]);
        end
        checks++;
        if (cursor_col !== 6'd2) begin errors++; $display("FAIL bs_col got %0d, required 2", cursor_col); end
        flush();
        model_byte(8'h0D); send_byte(8'h0D);
        model_byte(8'h08); send_byte(8'h08);
        wait_idle(ok);
        checks++;
        if (got_addr.size() != 0 || cursor_col !== 6'd0) begin
            errors++; $display("FAIL bs_at_col0 got %0d writes col %0d, required 0 writes col 0", got_addr.size(), cursor_col);
        end
    endtask

    task automatic test_lf_wrap();
        bit ok;
        while (m_row != ROWS - 1) begin
            model_byte(8'h0A); send_byte(8'h0A);
            wait_idle(ok);
        end
        flush();
        model_byte(8'h5A); send_byte(8'h5A);
        model_byte(8'h0A); send_byte(8'h0A);
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lfwrap_timeout"); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL lfwrap_count got %0d, required %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL lfwrap_write[%0d] got %0d/%h, required %0d/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (cursor_row !== 4'd0 || cursor_col !== 6'd1) begin
            errors++; $display("FAIL lfwrap_cursor got %0d,%0d, required 1,0", cursor_col, cursor_row);
        end
        model_byte(8'h0D); send_byte(8'h0D);
        wait_idle(ok);
        checks++;
        if (cursor_col !== 6'd0) begin errors++; $display("FAIL cr_col got %0d, required 0", cursor_col); end
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] b;
        bit clears;
        flush();
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: b = 8'($urandom_range(8'h20, 8'h7E));
                6: b = 8'h0D;
                7: b = 8'h0A;
                8: b = 8'h08;
                default: b = 8'h80 | 8'($urandom_range(0, 127));
            endcase
            clears = (b == 8'h0A) || (b >= 8'h20 && b <= 8'h7E && m_col == COLS - 1);
            model_byte(b);
            send_byte(b);
            if (clears) wait_idle(ok);
            else repeat ($urandom_range(3, 7)) @(posedge clk);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL random_timeout"); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL random_count got %0d, required %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL random_write[%0d] got %0d/%h, required %0d/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (cursor_col !== 6'(m_col) || cursor_row !== 4'(m_row) || ovf_cnt != 0) begin
            errors++; $display("FAIL random_cursor got %0d,%0d ovf %0d, required %0d,%0d ovf 0", cursor_col, cursor_row, ovf_cnt, m_col, m_row);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        flush();
        @(posedge clk); #1 clear_req = 1'b1;
        @(posedge clk); #1 clear_req = 1'b0;
        model_clear_all();
        repeat (5) @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            rx_data = 8'h61 + 8'(i); rx_valid = 1'b1;
            if (i < 16) model_byte(8'h61 + 8'(i));
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ovf_timeout"); end
        checks++;
        if (ovf_cnt != 4) begin errors++; $display("FAIL ovf_pulses got %0d, required 4", ovf_cnt); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL ovf_count got %0d, required %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL ovf_write[%0d] got %0d/%h, required %0d/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (cursor_col !== 6'd16 || cursor_row !== 4'd0) begin
            errors++; $display("FAIL ovf_cursor got %0d,%0d, required 16,0", cursor_col, cursor_row);
        end
    endtask

    task automatic test_pending();
        bit ok;
        flush();
        model_byte(8'h0A);
        send_byte(8'h0A);
        repeat (6) @(posedge clk); #1;
        rx_data = 8'h51; rx_valid = 1'b1; clear_req = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; clear_req = 1'b0;
        model_clear_all();
        model_byte(8'h51);
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pend_timeout"); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL pend_count got %0d, required %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL pend_write[%0d] got %0d/%h, required %0d/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (cursor_col !== 6'd1 || cursor_row !== 4'd0) begin
            errors++; $display("FAIL pend_cursor got %0d,%0d, required 1,0", cursor_col, cursor_row);
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        model_byte(8'h0A); send_byte(8'h0A);
        @(posedge clk); #1 clear_req = 1'b1;
        @(posedge clk); #1 clear_req = 1'b0;
        repeat (100) @(posedge clk);
        #3 reset = 1'b1;
        flush();
        repeat (5) @(negedge clk);
        checks++;
        if (got_addr.size() != 0 || busy !== 1'b1 || cursor_col !== 6'd0 || cursor_row !== 4'd0) begin
            errors++; $display("FAIL abort_in_reset got %0d ce busy=%b cursor %0d,%0d, required 0 ce busy=1 cursor 0,0",
                               got_addr.size(), busy, cursor_col, cursor_row);
        end
        flush();
        m_col = 0; m_row = 0;
        model_clear_all();
        @(posedge clk); #1 reset = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_timeout"); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL abort_count got %0d, required %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL abort_write[%0d] got %0d/%h, required %0d/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        clear_req = 1'b0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_wrap();
        test_backspace();
        test_lf_wrap();
        test_random();
        test_overflow();
        test_pending();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
